// File: rtl/gon_drain_ctrl.sv
// Drain controller on the slave side of the GON gather network: walks every (row, col)
// tag of the mapped PE region, fetches one value per tag and streams it to the output buffer.
module gon_drain_ctrl #(
    parameter int ROW_LEN   = 4,
    parameter int ID_LEN    = 5,
    parameter int VALUE_LEN = 32,
    parameter int ADDR_LEN  = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_LEN-1:0]   last_row,
    input  logic [ID_LEN-1:0]    last_col,
    input  logic [ADDR_LEN-1:0]  base_addr,
    output logic                 ready,
    output logic [ROW_LEN-1:0]   row_tag,
    output logic [ID_LEN-1:0]    col_tag,
    input  logic                 enable,
    input  logic [VALUE_LEN-1:0] value,
    output logic                 wr_en,
    output logic [ADDR_LEN-1:0]  wr_addr,
    output logic [VALUE_LEN-1:0] wr_data,
    input  logic                 wr_full,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    state_t               state, state_nxt;
    logic [ROW_LEN-1:0]   row_cnt, last_row_q;
    logic [ID_LEN-1:0]    col_cnt, last_col_q;
    logic [ADDR_LEN-1:0]  addr_cnt;
    logic [VALUE_LEN-1:0] hold;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 err_q;

    logic xfer, wr_fire, wait_expired, last_col_hit, last_pe;

    assign xfer         = (state == REQ) && enable;
    assign wr_fire      = (state == WRITE) && !wr_full;
    // Final waiting cycle: ready has then been up for exactly TIMEOUT cycles.
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign last_col_hit = (col_cnt == last_col_q);
    assign last_pe      = last_col_hit && (row_cnt == last_row_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (xfer) state_nxt = WRITE;
                     else if (wait_expired) state_nxt = DONE;
            WRITE:   if (wr_fire) state_nxt = last_pe ? DONE : REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt    <= '0;
            col_cnt    <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            addr_cnt   <= '0;
            hold       <= '0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    last_row_q <= last_row;
                    last_col_q <= last_col;
                    addr_cnt   <= base_addr;
                    row_cnt    <= '0;
                    col_cnt    <= '0;
                    wait_cnt   <= '0;
                    err_q      <= 1'b0;
                end
                // A transfer on the expiring cycle still wins over the timeout.
                REQ: if (xfer) begin
                    hold <= value;
                end else if (wait_expired) begin
                    err_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                WRITE: if (wr_fire) begin
                    addr_cnt <= addr_cnt + ADDR_LEN'(1);
                    wait_cnt <= '0;
                    if (!last_pe) begin
                        if (last_col_hit) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + ROW_LEN'(1);
                        end else begin
                            col_cnt <= col_cnt + ID_LEN'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready   = (state == REQ);
    assign row_tag = row_cnt;
    assign col_tag = col_cnt;
    assign wr_en   = wr_fire;
    assign wr_addr = addr_cnt;
    assign wr_data = hold;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = err_q;
endmodule

// File: tb/tb_gon_drain_ctrl.sv
// Directed bench for gon_drain_ctrl: a GON responder and output-buffer stand-in driven
// per cycle, with captured writes compared against hand-computed vectors.
module tb_gon_drain_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  last_row;
    logic [4:0]  last_col;
    logic [15:0] base_addr;
    logic        ready;
    logic [3:0]  row_tag;
    logic [4:0]  col_tag;
    logic        enable;
    logic [31:0] value;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        busy;
    logic        done;
    logic        err;

    gon_drain_ctrl #(
        .ROW_LEN(4), .ID_LEN(5), .VALUE_LEN(32), .ADDR_LEN(16), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .last_row(last_row), .last_col(last_col), .base_addr(base_addr),
        .ready(ready), .row_tag(row_tag), .col_tag(col_tag),
        .enable(enable), .value(value),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Results of the most recent drain
    logic [15:0] wa[64];
    logic [31:0] wd[64];
    int          n_wr, ready_cyc, done_at, held, bad_full;
    logic        err_done, err_c1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Cycle 0 is the cycle start is high; enable answers after en_delay ready cycles,
    // wr_full is held for the first full_cyc cycles spent in WRITE.
    task automatic drain(input logic [3:0] lr, input logic [4:0] lc, input logic [15:0] base,
                         input int en_delay, input int full_cyc, input bit never_en,
                         input int restart_at);
        int cyc, req_cnt, full_left;
        n_wr = 0; ready_cyc = 0; done_at = -1; held = 0; bad_full = 0;
        err_done = 1'b0; err_c1 = 1'b1;
        @(negedge clk);
        last_row = lr; last_col = lc; base_addr = base; start = 1'b1;
        cyc = 0; req_cnt = 0; full_left = full_cyc;
        while (cyc < 200 && done_at < 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (ready) begin
                req_cnt++;
                enable = !never_en && (req_cnt > en_delay);
            end else begin
                req_cnt = 0;
                enable  = 1'b0;
            end
            value = (32'(row_tag) << 4) + 32'(col_tag);
            if (busy && !ready && !done && full_left > 0) begin
                wr_full = 1'b1;
                full_left--;
            end else begin
                wr_full = 1'b0;
            end
            #1;
            if (cyc == 1) err_c1 = err;
            if (ready) ready_cyc++;
            if (wr_full) begin
                held++;
                if (wr_en || ready) bad_full++;
            end
            if (wr_en && n_wr < 64) begin
                wa[n_wr] = wr_addr;
                wd[n_wr] = wr_data;
                n_wr++;
            end
            if (done) begin
                done_at  = cyc;
                err_done = err;
            end
        end
        start = 1'b0; enable = 1'b0; wr_full = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; enable = 1'b0; wr_full = 1'b0; value = '0;
        last_row = '0; last_col = '0; base_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready, 0);   chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_err", err, 0);       chk("rst_row_tag", row_tag, 0);
        chk("rst_col_tag", col_tag, 0); chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        @(negedge clk); rst = 1'b0;

        // Stray enable in IDLE
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); enable = 1'b1; value = 32'h1234_5678;
            #1; chk("idle_enable_wr_en", wr_en, 0); chk("idle_enable_busy", busy, 0);
        end
        enable = 1'b0;

        // 2x3 region, immediate answers; a start during the drain must be ignored.
        // Done lands 2N+1 cycles after the start cycle (2N+2 cycles inclusive).
        drain(4'd1, 5'd2, 16'h0100, 0, 0, 1'b0, 4);
        chk("t1_nwr", n_wr, 6);
        for (int i = 0; i < 6; i++) begin
            chk("t1_addr", wa[i], 32'h100 + i);
            chk("t1_data", wd[i], (i / 3) * 16 + (i % 3));
        end
        chk("t1_ready_cyc", ready_cyc, 6);
        chk("t1_done_at", done_at, 13);
        chk("t1_err", err_done, 0);
        @(negedge clk); #1; chk("t1_busy_after", busy, 0); chk("t1_done_after", done, 0);

        // Single PE, enable delayed 5 cycles
        drain(4'd0, 5'd0, 16'h0040, 5, 0, 1'b0, 0);
        chk("t2_ready_cyc", ready_cyc, 6);
        chk("t2_nwr", n_wr, 1);
        chk("t2_addr", wa[0], 32'h40);
        chk("t2_data", wd[0], 0);
        chk("t2_done_at", done_at, 8);
        @(negedge clk); #1; chk("t2_busy_after", busy, 0);

        // Backpressure for 3 cycles on the first write
        drain(4'd0, 5'd1, 16'h0200, 0, 3, 1'b0, 0);
        chk("t3_held", held, 3);
        chk("t3_bad_full", bad_full, 0);
        chk("t3_nwr", n_wr, 2);
        chk("t3_addr0", wa[0], 32'h200);
        chk("t3_addr1", wa[1], 32'h201);
        chk("t3_data1", wd[1], 1);
        chk("t3_done_at", done_at, 8);

        // Timeout: no answer ever
        drain(4'd2, 5'd2, 16'h0300, 0, 0, 1'b1, 0);
        chk("t4_ready_cyc", ready_cyc, 8);
        chk("t4_nwr", n_wr, 0);
        chk("t4_done_at", done_at, 9);
        chk("t4_err_at_done", err_done, 1);
        @(negedge clk); #1; chk("t4_err_sticky", err, 1); chk("t4_busy_after", busy, 0);

        // Next start clears err; address wraps silently
        drain(4'd0, 5'd3, 16'hFFFE, 0, 0, 1'b0, 0);
        chk("t5_err_cleared", err_c1, 0);
        chk("t5_nwr", n_wr, 4);
        chk("t5_addr0", wa[0], 32'hFFFE);
        chk("t5_addr1", wa[1], 32'hFFFF);
        chk("t5_addr2", wa[2], 32'h0000);
        chk("t5_addr3", wa[3], 32'h0001);
        chk("t5_data3", wd[3], 3);
        chk("t5_err_at_done", err_done, 0);
        chk("t5_done_at", done_at, 9);

        // Asynchronous reset while stalled in WRITE
        @(negedge clk); last_row = '0; last_col = '0; base_addr = 16'h0050; start = 1'b1;
        @(negedge clk); start = 1'b0; enable = 1'b1; value = 32'hDEAD_BEEF;
        @(negedge clk); enable = 1'b0; wr_full = 1'b1;
        #1; chk("t6_stall_wr_en", wr_en, 0); chk("t6_stall_busy", busy, 1);
        chk("t6_stall_data", wr_data, 32'hDEAD_BEEF);
        #1; rst = 1'b1;
        #1;
        chk("t6_rst_ready", ready, 0);   chk("t6_rst_wr_en", wr_en, 0);
        chk("t6_rst_busy", busy, 0);     chk("t6_rst_done", done, 0);
        chk("t6_rst_err", err, 0);       chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_wr_data", wr_data, 0);
        @(negedge clk); rst = 1'b0; wr_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t6_post_wr_en", wr_en, 0); chk("t6_post_done", done, 0);
            chk("t6_post_busy", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
